// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned c_ADDR_W       = 22;
    localparam int unsigned c_DATA_W       = 22;
    localparam int unsigned c_MAX_DATA_RUN = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF   = 1'b0,
        PORT_DATA = 1'b1
    } port_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_select.sv
`default_nettype none
// ============================================================================
// Module      : arb_select
// Description : Combinational fetch/data selection with starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = c_MAX_DATA_RUN,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             i_if_req,
    input  logic             i_if_valid,
    input  logic             i_d_req,
    input  logic             i_d_valid,
    input  logic [CNT_W-1:0] i_run_cnt,
    output logic             o_grant,
    output port_t            o_grant_port
);

    logic w_if_elig;
    logic w_d_elig;

    // A port completing this cycle still holds its request; it must not be re-granted.
    always_comb begin
        w_if_elig    = i_if_req & ~i_if_valid;
        w_d_elig     = i_d_req & ~i_d_valid;
        o_grant      = w_if_elig | w_d_elig;
        o_grant_port = PORT_DATA;
        if (w_if_elig && (!w_d_elig || (i_run_cnt == CNT_W'(MAX_DATA_RUN)))) begin
            o_grant_port = PORT_IF;
        end
    end

endmodule : arb_select
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Fetch/data arbiter onto a single-port synchronous memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = c_ADDR_W,
    parameter int unsigned DATA_W       = c_DATA_W,
    parameter int unsigned MAX_DATA_RUN = c_MAX_DATA_RUN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int unsigned c_CNT_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    port_t               r_port;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_CNT_W-1:0]  r_run_cnt;
    logic                r_if_valid;
    logic                r_d_valid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                w_grant;
    port_t               w_grant_port;
    logic                w_take;

    arb_select #(
        .MAX_DATA_RUN (MAX_DATA_RUN),
        .CNT_W        (c_CNT_W)
    ) u_arb_select (
        .i_if_req     (if_req),
        .i_if_valid   (r_if_valid),
        .i_d_req      (d_req),
        .i_d_valid    (r_d_valid),
        .i_run_cnt    (r_run_cnt),
        .o_grant      (w_grant),
        .o_grant_port (w_grant_port)
    );

    assign w_take = (r_state == ST_IDLE) && w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_grant) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   w_state_nxt = r_we ? ST_IDLE : ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we = (r_state == ST_ISSUE) && r_we;
    end

    // Request latches: the in-flight access is decoupled from the live request inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port    <= PORT_IF;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_run_cnt <= '0;
        end else if (w_take) begin
            r_port <= w_grant_port;
            if (w_grant_port == PORT_DATA) begin
                r_addr  <= d_addr;
                r_we    <= d_we;
                r_wdata <= d_wdata;
                if (!if_req) begin
                    r_run_cnt <= '0;
                end else if (r_run_cnt != c_CNT_W'(MAX_DATA_RUN)) begin
                    r_run_cnt <= r_run_cnt + c_CNT_W'(1);
                end
            end else begin
                r_addr    <= if_addr;
                r_we      <= 1'b0;
                r_run_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            if ((r_state == ST_ISSUE) && r_we) begin
                r_d_valid <= 1'b1;
            end else if (r_state == ST_CAPTURE) begin
                if (r_port == PORT_DATA) begin
                    r_d_rdata <= mem_rdata;
                    r_d_valid <= 1'b1;
                end else begin
                    r_if_rdata <= mem_rdata;
                    r_if_valid <= 1'b1;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_valid  = r_if_valid;
    assign d_valid   = r_d_valid;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall     = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [21:0] if_addr = '0;
    logic [21:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [21:0] d_addr = '0;
    logic [21:0] d_wdata = '0;
    logic [21:0] d_rdata;
    logic        d_valid;
    logic [21:0] mem_addr;
    logic        mem_we;
    logic [21:0] mem_wdata;
    logic [21:0] mem_rdata = '0;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    // Read-only memory image; read data appears the cycle after the address.
    function automatic logic [21:0] rom(input logic [21:0] a);
        case (a)
            22'h000008: rom = 22'h2A5A5A;
            22'h000040: rom = 22'h012345;
            22'h0002C0: rom = 22'h0ABCDE;
            22'h000010: rom = 22'h155555;
            22'h000A00: rom = 22'h3C3C3C;
            22'h000B00: rom = 22'h0F0F0F;
            default:    rom = a ^ 22'h155555;
        endcase
    endfunction

    always @(posedge clk) mem_rdata <= rom(mem_addr);

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_valid got %b want 0", d_valid); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 22'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 22'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        n_checks++; if (if_rdata !== 22'h0) begin n_fail++; $display("FAIL reset_if_rdata got %h want 0", if_rdata); end
        n_checks++; if (d_rdata !== 22'h0) begin n_fail++; $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        @(negedge clk); if_req = 1'b1; if_addr = 22'h000008;
        @(negedge clk);
        n_checks++; if (mem_addr !== 22'h000008) begin n_fail++; $display("FAIL fetch_issue_addr got %h want 000008", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_issue_we got %b want 0", mem_we); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_issue_stall got %b want 1", stall); end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_early_valid got %b want 0", if_valid); end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got %b want 1", if_valid); end
        n_checks++; if (if_rdata !== 22'h2A5A5A) begin n_fail++; $display("FAIL fetch_rdata got %h want 2a5a5a", if_rdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fetch_done_stall got %b want 0", stall); end
        if_req = 1'b0;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_width got %b want 0", if_valid); end
        n_checks++; if (if_rdata !== 22'h2A5A5A) begin n_fail++; $display("FAIL fetch_rdata_hold got %h want 2a5a5a", if_rdata); end
    endtask

    task automatic test_store();
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 22'h000100; d_wdata = 22'h00001F;
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL store_we got %b want 1", mem_we); end
        n_checks++; if (mem_addr !== 22'h000100) begin n_fail++; $display("FAIL store_addr got %h want 000100", mem_addr); end
        n_checks++; if (mem_wdata !== 22'h00001F) begin n_fail++; $display("FAIL store_wdata got %h want 00001f", mem_wdata); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL store_stall got %b want 1", stall); end
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL store_early_valid got %b want 0", d_valid); end
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL store_valid got %b want 1", d_valid); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL store_we_single got %b want 0", mem_we); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_done_stall got %b want 0", stall); end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL store_pulse_width got %b want 0", d_valid); end
        n_checks++; if (mem_addr !== 22'h000100) begin n_fail++; $display("FAIL store_addr_hold got %h want 000100", mem_addr); end
        n_checks++; if (mem_wdata !== 22'h00001F) begin n_fail++; $display("FAIL store_wdata_hold got %h want 00001f", mem_wdata); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        if_req = 1'b1; if_addr = 22'h0002C0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 22'h000040;
        @(negedge clk);
        n_checks++; if (mem_addr !== 22'h000040) begin n_fail++; $display("FAIL simul_data_first got %h want 000040", mem_addr); end
        repeat (2) @(negedge clk);
        n_checks++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL simul_d_valid got %b want 1", d_valid); end
        n_checks++; if (d_rdata !== 22'h012345) begin n_fail++; $display("FAIL simul_d_rdata got %h want 012345", d_rdata); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL simul_if_early got %b want 0", if_valid); end
        d_req = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_addr !== 22'h0002C0) begin n_fail++; $display("FAIL simul_fetch_next got %h want 0002c0", mem_addr); end
        repeat (2) @(negedge clk);
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL simul_if_valid got %b want 1", if_valid); end
        n_checks++; if (if_rdata !== 22'h0ABCDE) begin n_fail++; $display("FAIL simul_if_rdata got %h want 0abcde", if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_capture();
        @(negedge clk); if_req = 1'b1; if_addr = 22'h000010;
        @(negedge clk);
        n_checks++; if (mem_addr !== 22'h000010) begin n_fail++; $display("FAIL rstcap_issue_addr got %h want 000010", mem_addr); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rstcap_no_valid got %b want 0", if_valid); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstcap_we got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 22'h0) begin n_fail++; $display("FAIL rstcap_addr got %h want 0", mem_addr); end
        n_checks++; if (if_rdata !== 22'h0) begin n_fail++; $display("FAIL rstcap_rdata got %h want 0", if_rdata); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_addr !== 22'h000010) begin n_fail++; $display("FAIL rstcap_rearb_addr got %h want 000010", mem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rstcap_rearb_early got %b want 0", if_valid); end
        repeat (2) @(negedge clk);
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL rstcap_valid got %b want 1", if_valid); end
        n_checks++; if (if_rdata !== 22'h155555) begin n_fail++; $display("FAIL rstcap_rdata_final got %h want 155555", if_rdata); end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    // Fetch drops its request only during data completions so the run counter can fill.
    task automatic test_starvation();
        logic [9:0] got;
        int         n;
        int         cyc;
        got = '0; n = 0; cyc = 0;
        @(negedge clk);
        if_addr = 22'h000A00; d_addr = 22'h000B00; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (d_valid) begin
                n_checks++; if (d_rdata !== 22'h0F0F0F) begin n_fail++; $display("FAIL starve_d_rdata got %h want 0f0f0f", d_rdata); end
                n++;
            end else if (if_valid) begin
                n_checks++; if (if_rdata !== 22'h3C3C3C) begin n_fail++; $display("FAIL starve_if_rdata got %h want 3c3c3c", if_rdata); end
                got[n] = 1'b1;
                n++;
            end
            if (n == 10) begin
                if_req = 1'b0; d_req = 1'b0;
            end else begin
                if_req = ~d_valid;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        n_checks++; if (n !== 10) begin n_fail++; $display("FAIL starve_timeout completions %0d want 10", n); end
        n_checks++; if (got !== 10'b1000010000) begin n_fail++; $display("FAIL starve_order got %b want 1000010000", got); end
        @(negedge clk);
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ((mem_we !== 1'b0) || (stall !== 1'b0) || (if_valid !== 1'b0) || (d_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL idle_quiet cycle %0d got we=%b stall=%b ifv=%b dv=%b want all 0",
                         i, mem_we, stall, if_valid, d_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_reset_capture();
        test_starvation();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
